spart: RTL

//  Special-purpose async receiver/transmitter; the bus slave of the UART driver FSM.

---
 rtl/spart_pkg.sv | 22 ++
 rtl/spart_baud_gen.sv | 26 ++
 rtl/spart.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/spart_pkg.sv
// Shared constants, register map and FSM encodings for the spart bus UART.
`timescale 1ns/1ps
package spart_pkg;
  localparam logic [1:0] ADDR_BUF  = 2'b00;
  localparam logic [1:0] ADDR_STAT = 2'b01;
  localparam logic [1:0] ADDR_DBL  = 2'b10;
  localparam logic [1:0] ADDR_DBH  = 2'b11;

  localparam int ST_TBR = 0;
  localparam int ST_RDA = 1;
  localparam int ST_FE  = 2;
  localparam int ST_OVR = 3;

  localparam logic [15:0] DEFAULT_DIV = 16'd162;
  localparam int          OVERSAMPLE  = 16;
  localparam int          FRAME_BITS  = 10;
  localparam logic [3:0]  TICK_LAST   = 4'(OVERSAMPLE - 1);
  localparam logic [3:0]  TICK_MID    = 4'(OVERSAMPLE / 2 - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
endpackage

// File: rtl/spart_baud_gen.sv
// Programmable baud enable: one-cycle en pulse every max(div,1) clocks.
`timescale 1ns/1ps
module spart_baud_gen
  import spart_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] div,
  input  logic        reload,
  output logic        en
);
  logic [15:0] cnt_q, cnt_d, load_val;

  always_comb begin
    load_val = (div > 16'd1) ? div - 16'd1 : 16'd0;
    cnt_d    = cnt_q - 16'd1;
    if (reload || cnt_q == 16'd0) cnt_d = load_val;
  end

  assign en = (cnt_q == 16'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= DEFAULT_DIV - 16'd1;
    else      cnt_q <= cnt_d;
  end
endmodule

// File: rtl/spart.sv
// Bus-slave UART: register decode, 8N1 transmitter and 16x-oversampled receiver.
`timescale 1ns/1ps
module spart
  import spart_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       iocs,
  input  logic       iorw,
  input  logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  output logic       rda,
  output logic       tbr,
  output logic       txd,
  input  logic       rxd
);
  logic        wr, rd, wr_buf, rd_buf, rd_stat, reload, baud_en, rx_fall;
  logic [7:0]  rd_data;
  logic [15:0] div_q, div_d;

  tx_state_e   tx_state_q, tx_state_d;
  logic [3:0]  tx_tick_q, tx_tick_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic        tbr_q, tbr_d, txd_q, txd_d;

  logic        rx_sync1_q, rx_sync2_q, rx_prev_q;
  rx_state_e   rx_state_q, rx_state_d;
  logic [3:0]  rx_tick_q, rx_tick_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_shift_q, rx_shift_d, rx_buf_q, rx_buf_d;
  logic        rda_q, rda_d, fe_q, fe_d, ovr_q, ovr_d;

  assign wr      = iocs && !iorw;
  assign rd      = iocs && iorw;
  assign wr_buf  = wr && ioaddr == ADDR_BUF;
  assign rd_buf  = rd && ioaddr == ADDR_BUF;
  assign rd_stat = rd && ioaddr == ADDR_STAT;
  assign rx_fall = rx_prev_q && !rx_sync2_q;

  // The baud counter sees the next divisor so a write reloads with the new value.
  always_comb begin
    div_d  = div_q;
    reload = 1'b0;
    if (wr && ioaddr == ADDR_DBL) begin div_d[7:0]  = databus; reload = 1'b1; end
    if (wr && ioaddr == ADDR_DBH) begin div_d[15:8] = databus; reload = 1'b1; end
  end

  spart_baud_gen u_baud (
    .clk    (clk),
    .rst    (rst),
    .div    (div_d),
    .reload (reload),
    .en     (baud_en)
  );

  always_comb begin
    tx_state_d = tx_state_q;
    tx_tick_d  = tx_tick_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tbr_d      = tbr_q;
    txd_d      = txd_q;
    case (tx_state_q)
      TX_IDLE: if (wr_buf && tbr_q) begin
        tx_shift_d = databus;
        tx_tick_d  = 4'd0;
        tx_state_d = TX_START;
        tbr_d      = 1'b0;
        txd_d      = 1'b0;
      end
      TX_START: if (baud_en) begin
        tx_tick_d = tx_tick_q + 4'd1;
        if (tx_tick_q == TICK_LAST) begin
          tx_state_d = TX_DATA;
          tx_bit_d   = 3'd0;
          txd_d      = tx_shift_q[0];
        end
      end
      TX_DATA: if (baud_en) begin
        tx_tick_d = tx_tick_q + 4'd1;
        if (tx_tick_q == TICK_LAST) begin
          if (tx_bit_q == 3'd7) begin
            tx_state_d = TX_STOP;
            txd_d      = 1'b1;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_shift_d = tx_shift_q >> 1;
            txd_d      = tx_shift_q[1];
          end
        end
      end
      default: if (baud_en) begin
        tx_tick_d = tx_tick_q + 4'd1;
        if (tx_tick_q == TICK_LAST) begin
          tx_state_d = TX_IDLE;
          tbr_d      = 1'b1;
        end
      end
    endcase
  end

  // A buffer load in the same cycle as a buffer read wins and is not an overrun.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_tick_d  = rx_tick_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_buf_d   = rx_buf_q;
    rda_d      = rda_q;
    fe_d       = fe_q;
    ovr_d      = ovr_q;
    if (rd_buf) begin rda_d = 1'b0; ovr_d = 1'b0; end
    if (rd_stat) fe_d = 1'b0;
    case (rx_state_q)
      RX_IDLE: if (rx_fall) begin
        rx_state_d = RX_START;
        rx_tick_d  = 4'd0;
      end
      RX_START: if (baud_en) begin
        rx_tick_d = rx_tick_q + 4'd1;
        if (rx_tick_q == TICK_MID) begin
          rx_tick_d  = 4'd0;
          rx_bit_d   = 3'd0;
          rx_state_d = rx_sync2_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: if (baud_en) begin
        rx_tick_d = rx_tick_q + 4'd1;
        if (rx_tick_q == TICK_LAST) begin
          rx_shift_d = {rx_sync2_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
        end
      end
      default: if (baud_en) begin
        rx_tick_d = rx_tick_q + 4'd1;
        if (rx_tick_q == TICK_LAST) begin
          rx_state_d = RX_IDLE;
          if (rx_sync2_q) begin
            rx_buf_d = rx_shift_q;
            rda_d    = 1'b1;
            if (rda_q && !rd_buf) ovr_d = 1'b1;
          end else begin
            fe_d = 1'b1;
          end
        end
      end
    endcase
  end

  always_comb begin
    rd_data = 8'h00;
    case (ioaddr)
      ADDR_BUF: rd_data = rx_buf_q;
      ADDR_STAT: begin
        rd_data[ST_TBR] = tbr_q;
        rd_data[ST_RDA] = rda_q;
        rd_data[ST_FE]  = fe_q;
        rd_data[ST_OVR] = ovr_q;
      end
      ADDR_DBL: rd_data = div_q[7:0];
      default:  rd_data = div_q[15:8];
    endcase
  end

  assign databus = rd ? rd_data : 8'hzz;
  assign rda     = rda_q;
  assign tbr     = tbr_q;
  assign txd     = txd_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q      <= DEFAULT_DIV;
      tx_state_q <= TX_IDLE;
      tx_tick_q  <= 4'd0;
      tx_bit_q   <= 3'd0;
      tx_shift_q <= 8'h00;
      tbr_q      <= 1'b1;
      txd_q      <= 1'b1;
      rx_sync1_q <= 1'b1;
      rx_sync2_q <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_tick_q  <= 4'd0;
      rx_bit_q   <= 3'd0;
      rx_shift_q <= 8'h00;
      rx_buf_q   <= 8'h00;
      rda_q      <= 1'b0;
      fe_q       <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      div_q      <= div_d;
      tx_state_q <= tx_state_d;
      tx_tick_q  <= tx_tick_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tbr_q      <= tbr_d;
      txd_q      <= txd_d;
      rx_sync1_q <= rxd;
      rx_sync2_q <= rx_sync1_q;
      rx_prev_q  <= rx_sync2_q;
      rx_state_q <= rx_state_d;
      rx_tick_q  <= rx_tick_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_buf_q   <= rx_buf_d;
      rda_q      <= rda_d;
      fe_q       <= fe_d;
      ovr_q      <= ovr_d;
    end
  end
endmodule
